weight_fetch_ctrl: RTL and testbench
====================================

// Module: weight_fetch_ctrl
// PURPOSE
//  Owns one neuron's weight BRAM (DEPTH x DW, written on negedge CLK, read data on DO).
//  Two jobs, never overlapping:
//   - LOAD: accepts a weight image from the loader stream and writes it.
//   - FETCH: on START, reads all DEPTH weights in address order and streams them to the
//     MAC stage over a valid/ready handshake, with backpressure.
//  Sits between the weight loader and the neuron MAC.
// PARAMETERS
//  DEPTH  28  weights per neuron; addresses 0..DEPTH-1
//  AW     5   BRAM address width; DEPTH <= 2**AW
//  DW     16  weight width, fixed-point
// PORTS
//  CLK        in   1   clock; all logic on posedge (BRAM itself uses negedge)
//  RST        in   1   synchronous, active-high reset
//  START      in   1   one-cycle pulse; starts a fetch pass (honoured in IDLE only)
//  BUSY       out  1   high in LOAD, FETCH and DRAIN
//  DONE       out  1   one-cycle pulse when a fetch pass completes
//  LOAD_DONE  out  1   one-cycle pulse when DEPTH words have been loaded
//  LD_VALID   in   1   loader word valid
//  LD_DATA    in   DW  loader word
//  LD_READY   out  1   = (state==IDLE && !START) || state==LOAD
//  W_VALID    out  1   weight stream valid (skid FIFO not empty)
//  W_DATA     out  DW  weight at FIFO head
//  W_LAST     out  1   high with the weight from address DEPTH-1
//  W_READY    in   1   MAC accepts the weight
//  BRAM_ADDR  out  AW  to BRAM ADDR
//  BRAM_DI    out  DW  to BRAM DI
//  BRAM_EN    out  1   to BRAM EN
//  BRAM_WE    out  1   to BRAM WE
//  BRAM_DO    in   DW  from BRAM DO
// BEHAVIOUR
//  Reset values (RST high at posedge):
//   - state=IDLE; all pointers, counts and the FIFO cleared.
//   - Outputs low/zero: BUSY, DONE, LOAD_DONE, W_VALID, W_LAST, W_DATA, BRAM_EN, BRAM_WE,
//     BRAM_ADDR, BRAM_DI.
//   - RST mid-LOAD or mid-FETCH aborts at once. No DONE/LOAD_DONE pulse.
//     Words already written stay in the BRAM.
//  BRAM port outputs are registered.
//  BRAM timing: a read issued in cycle n (EN=1, WE=0 driven from posedge n) returns
//   BRAM_DO valid at posedge n+1, where it is pushed into the FIFO (in_flight flag).
//  States and transitions:
//   - IDLE: START -> FETCH (START has priority over LD_VALID);
//     else LD_VALID&LD_READY -> LOAD and that word is written to addr 0.
//   - LOAD: each LD_VALID&LD_READY writes LD_DATA at ld_ptr (EN=WE=1), ld_ptr++.
//     After the write to DEPTH-1 -> IDLE; LOAD_DONE pulses the next cycle.
//     START is ignored in LOAD.
//   - FETCH: issue a read at rd_ptr when (fifo_count + in_flight) < 2, then rd_ptr++.
//     After issuing DEPTH-1 -> DRAIN.
//   - DRAIN: no new reads. When the last word has been accepted (W_VALID&W_READY&W_LAST)
//     -> IDLE; DONE pulses in that same cycle.
//  Skid FIFO: 2 entries.
//   - Push and pop in the same cycle are both honoured.
//   - It never overflows, by the issue rule.
//   - W_DATA/W_VALID come straight from the FIFO head; they are stable while
//     W_VALID && !W_READY.
//   - W_LAST is a tag stored with each entry.
//  Throughput: 1 weight/cycle with W_READY held high. First W_VALID 2 cycles after START.
//  Idle outputs: BRAM_EN=0 whenever no access is issued; BRAM_WE=1 only on load writes.
//  START outside IDLE is ignored; it is not queued.
//  Pointers stop at DEPTH-1 and do not wrap. Unused addresses DEPTH..2**AW-1 are never
//   driven.
// TESTING
//  1. Load, then fetch:
//     stimulus: reset; stream 28 words 0x0100+i with LD_VALID held high; then pulse START
//     with W_READY=1.
//     required: LOAD_DONE pulses once; W_DATA = 0x0100..0x011B in order; W_LAST only on
//     0x011B; DONE in the same cycle as that accept; 28 consecutive beats.
//  2. Backpressure:
//     stimulus: W_READY toggles 1,0,0,1 repeatedly during a fetch.
//     required: no word lost or duplicated; W_DATA held while stalled; BRAM_EN never
//     asserted with 2 entries held.
//  3. Collision in IDLE:
//     stimulus: START and LD_VALID high in the same IDLE cycle.
//     required: LD_READY=0 that cycle; FETCH entered; no BRAM write.
//  4. Ignored START:
//     stimulus: START pulsed mid-LOAD (after 10 words) and mid-FETCH.
//     required: both ignored; load completes at word 28; exactly one DONE.
//  5. Reset mid-fetch:
//     stimulus: RST after 5 beats.
//     required: next cycle all outputs zero, state IDLE; a following START streams again
//     from address 0.
//  6. Stall at the last weight:
//     stimulus: W_READY=0 while the DEPTH-1 word is at the FIFO head.
//     required: stays in DRAIN with W_VALID=1 and W_LAST=1; DONE only once W_READY rises.

Source files
------------

// File: rtl/weight_fetch_ctrl_if.sv
// Weight fetch controller bus bundle.
// Groups the control pulses, the loader stream, the MAC weight stream and the BRAM port
// of one neuron's weight fetch controller.
//   master : controller side (drives busy/done/load_done, ld_ready, w_*, bram_addr/di/en/we)
//   slave  : environment side (drives start, ld_valid/ld_data, w_ready, bram_do)
interface weight_fetch_ctrl_if #(
   parameter int unsigned AW = 5,
   parameter int unsigned DW = 16
);
   logic          start;
   logic          busy;
   logic          done;
   logic          load_done;
   logic          ld_valid;
   logic [DW-1:0] ld_data;
   logic          ld_ready;
   logic          w_valid;
   logic [DW-1:0] w_data;
   logic          w_last;
   logic          w_ready;
   logic [AW-1:0] bram_addr;
   logic [DW-1:0] bram_di;
   logic          bram_en;
   logic          bram_we;
   logic [DW-1:0] bram_do;

   modport master (
      input  start, ld_valid, ld_data, w_ready, bram_do,
      output busy, done, load_done, ld_ready, w_valid, w_data, w_last,
             bram_addr, bram_di, bram_en, bram_we
   );

   modport slave (
      output start, ld_valid, ld_data, w_ready, bram_do,
      input  busy, done, load_done, ld_ready, w_valid, w_data, w_last,
             bram_addr, bram_di, bram_en, bram_we
   );
endinterface

// File: rtl/weight_fetch_ctrl.sv
// Weight fetch controller for one neuron's weight BRAM (DEPTH x DW).
// LOAD writes a DEPTH-word image from the loader stream into the BRAM; FETCH reads all
// DEPTH weights in address order and streams them to the MAC through a 2-entry skid FIFO
// with valid/ready backpressure. The two jobs never overlap.
// Ports:
//   clk  : clock, all logic on posedge (the BRAM itself works on negedge)
//   rst  : synchronous active-high reset
//   bus  : weight_fetch_ctrl_if.master
//          start/busy/done/load_done  control pulses and status
//          ld_valid/ld_data/ld_ready  loader stream
//          w_valid/w_data/w_last/w_ready  weight stream to the MAC
//          bram_addr/di/en/we (registered), bram_do  BRAM port
module weight_fetch_ctrl #(
   parameter int unsigned DEPTH = 28,
   parameter int unsigned AW    = 5,
   parameter int unsigned DW    = 16
) (
   input logic                  clk,
   input logic                  rst,
   weight_fetch_ctrl_if.master  bus
);

   typedef enum logic [1:0] {StIdle, StLoad, StFetch, StDrain} state_e;

   localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

   state_e        state_q;
   logic [AW-1:0] ld_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic          in_flight_q;
   logic          in_flight_last_q;
   logic          load_last_q;
   logic          load_done_q;
   logic          busy_q;
   logic          bram_en_q;
   logic          bram_we_q;
   logic [AW-1:0] bram_addr_q;
   logic [DW-1:0] bram_di_q;
   logic [DW-1:0] fifo_data_q [2];
   logic          fifo_last_q [2];
   logic [1:0]    fifo_count_q;

   logic push;
   logic pop;
   logic issue_ok;

   // The read issued last cycle returns its data now and is pushed.
   assign push = in_flight_q;
   assign pop  = (fifo_count_q != 2'd0) && bus.w_ready;
   // Issue only if the FIFO still has room for this read after this cycle's pop; this
   // keeps 1 weight/cycle under full-rate ready and never overflows the 2 entries.
   assign issue_ok = (({1'b0, fifo_count_q} + {2'b00, in_flight_q}) - {2'b00, pop}) < 3'd2;

   assign bus.ld_ready  = ((state_q == StIdle) && !bus.start) || (state_q == StLoad);
   assign bus.w_valid   = (fifo_count_q != 2'd0);
   assign bus.w_data    = fifo_data_q[0];
   assign bus.w_last    = bus.w_valid && fifo_last_q[0];
   assign bus.done      = (state_q == StDrain) && pop && fifo_last_q[0];
   assign bus.busy      = busy_q;
   assign bus.load_done = load_done_q;
   assign bus.bram_addr = bram_addr_q;
   assign bus.bram_di   = bram_di_q;
   assign bus.bram_en   = bram_en_q;
   assign bus.bram_we   = bram_we_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= StIdle;
         ld_ptr_q         <= '0;
         rd_ptr_q         <= '0;
         in_flight_q      <= 1'b0;
         in_flight_last_q <= 1'b0;
         load_last_q      <= 1'b0;
         load_done_q      <= 1'b0;
         busy_q           <= 1'b0;
         bram_en_q        <= 1'b0;
         bram_we_q        <= 1'b0;
         bram_addr_q      <= '0;
         bram_di_q        <= '0;
         fifo_data_q[0]   <= '0;
         fifo_data_q[1]   <= '0;
         fifo_last_q[0]   <= 1'b0;
         fifo_last_q[1]   <= 1'b0;
         fifo_count_q     <= 2'd0;
      end else begin
         bram_en_q        <= 1'b0;
         bram_we_q        <= 1'b0;
         in_flight_q      <= 1'b0;
         in_flight_last_q <= 1'b0;
         load_last_q      <= 1'b0;
         // LOAD_DONE trails the final write by one cycle.
         load_done_q      <= load_last_q;

         // Skid FIFO, entry 0 is the head.
         case (fifo_count_q)
            2'd0: begin
               if (push) begin
                  fifo_data_q[0] <= bus.bram_do;
                  fifo_last_q[0] <= in_flight_last_q;
                  fifo_count_q   <= 2'd1;
               end
            end
            2'd1: begin
               if (push && pop) begin
                  fifo_data_q[0] <= bus.bram_do;
                  fifo_last_q[0] <= in_flight_last_q;
               end else if (push) begin
                  fifo_data_q[1] <= bus.bram_do;
                  fifo_last_q[1] <= in_flight_last_q;
                  fifo_count_q   <= 2'd2;
               end else if (pop) begin
                  fifo_count_q   <= 2'd0;
               end
            end
            default: begin
               if (pop) begin
                  fifo_data_q[0] <= fifo_data_q[1];
                  fifo_last_q[0] <= fifo_last_q[1];
                  if (push) begin
                     fifo_data_q[1] <= bus.bram_do;
                     fifo_last_q[1] <= in_flight_last_q;
                  end else begin
                     fifo_count_q   <= 2'd1;
                  end
               end
            end
         endcase

         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  // First read goes out straight away so W_VALID rises 2 cycles after START.
                  busy_q           <= 1'b1;
                  bram_en_q        <= 1'b1;
                  bram_addr_q      <= '0;
                  in_flight_q      <= 1'b1;
                  in_flight_last_q <= (LastAddr == '0);
                  rd_ptr_q         <= (LastAddr == '0) ? '0 : AW'(1);
                  state_q          <= (LastAddr == '0) ? StDrain : StFetch;
               end else if (bus.ld_valid) begin
                  bram_en_q   <= 1'b1;
                  bram_we_q   <= 1'b1;
                  bram_addr_q <= '0;
                  bram_di_q   <= bus.ld_data;
                  if (LastAddr == '0) begin
                     load_last_q <= 1'b1;
                  end else begin
                     busy_q   <= 1'b1;
                     ld_ptr_q <= AW'(1);
                     state_q  <= StLoad;
                  end
               end
            end
            StLoad: begin
               if (bus.ld_valid) begin
                  bram_en_q   <= 1'b1;
                  bram_we_q   <= 1'b1;
                  bram_addr_q <= ld_ptr_q;
                  bram_di_q   <= bus.ld_data;
                  if (ld_ptr_q == LastAddr) begin
                     load_last_q <= 1'b1;
                     busy_q      <= 1'b0;
                     state_q     <= StIdle;
                  end else begin
                     ld_ptr_q <= ld_ptr_q + AW'(1);
                  end
               end
            end
            StFetch: begin
               if (issue_ok) begin
                  bram_en_q        <= 1'b1;
                  bram_addr_q      <= rd_ptr_q;
                  in_flight_q      <= 1'b1;
                  in_flight_last_q <= (rd_ptr_q == LastAddr);
                  if (rd_ptr_q == LastAddr) begin
                     state_q <= StDrain;
                  end else begin
                     rd_ptr_q <= rd_ptr_q + AW'(1);
                  end
               end
            end
            StDrain: begin
               if (pop && fifo_last_q[0]) begin
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Directed bench for weight_fetch_ctrl with a behavioural negedge BRAM and a passive
// stream monitor; each scenario task checks its own results inline.
module tb_weight_fetch_ctrl;
   localparam int DEPTH = 28;
   localparam int AW    = 5;
   localparam int DW    = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   weight_fetch_ctrl_if #(.AW(AW), .DW(DW)) bus ();

   weight_fetch_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Behavioural BRAM: write and read on negedge.
   logic [DW-1:0] mem [2**AW];
   always @(negedge clk) begin
      if (bus.bram_en) begin
         if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_di;
         else             bus.bram_do <= mem[bus.bram_addr];
      end
   end

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [DW-1:0] exp_w [DEPTH];

   // Monitor state
   logic [DW-1:0] beat_d[$];
   logic          beat_l[$];
   int            beat_c[$];
   int first_valid_cyc = -1;
   int done_cnt = 0, load_done_cnt = 0, wr_cnt = 0, rd_cnt = 0, acc_cnt = 0;
   int en_viol = 0, hold_viol = 0, done_bad = 0;
   logic prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;

   always @(negedge clk) begin
      if (rst) begin
         rd_cnt = 0;
         acc_cnt = 0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (!bus.w_valid || bus.w_data !== prev_data)) hold_viol++;
         prev_stall = bus.w_valid && !bus.w_ready;
         prev_data  = bus.w_data;
         // Reads issued minus beats accepted = entries held this cycle.
         if (bus.bram_en && !bus.bram_we) begin
            if (rd_cnt - acc_cnt >= 2) en_viol++;
            rd_cnt++;
         end
         if (bus.bram_en && bus.bram_we) wr_cnt++;
         if (bus.w_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (bus.w_valid && bus.w_ready) begin
            beat_d.push_back(bus.w_data);
            beat_l.push_back(bus.w_last);
            beat_c.push_back(cyc);
            acc_cnt++;
         end
         if (bus.done) done_cnt++;
         if (bus.done !== (bus.w_valid && bus.w_ready && bus.w_last)) done_bad++;
         if (bus.load_done) load_done_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int stream_errs();
      int e = 0;
      if (beat_d.size() != DEPTH) e++;
      for (int i = 0; i < beat_d.size() && i < DEPTH; i++) begin
         if (beat_d[i] !== exp_w[i]) e++;
         if (beat_l[i] !== (i == DEPTH - 1)) e++;
      end
      return e;
   endfunction

   function automatic int image_errs();
      int e = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_w[i]) e++;
      return e;
   endfunction

   task automatic clear_mon();
      beat_d.delete();
      beat_l.delete();
      beat_c.delete();
      first_valid_cyc = -1;
      hold_viol = 0;
      en_viol = 0;
      done_bad = 0;
   endtask

   // Streams exp_w through the loader; optional START pulse alongside word start_at.
   task automatic load_image(input int start_at);
      for (int i = 0; i < DEPTH; i++) begin
         bus.ld_valid = 1'b1;
         bus.ld_data  = exp_w[i];
         bus.start    = (i == start_at);
         tick();
      end
      bus.ld_valid = 1'b0;
      bus.start    = 1'b0;
      repeat (3) tick();
   endtask

   // mode 0: ready held high; mode 1: ready pattern 1,0,0,1. Optional START at cycle mid.
   task automatic wait_done(input int mode, input int mid, input int d0, output bit to);
      for (int n = 0; n < 400 && done_cnt == d0; n++) begin
         bus.w_ready = (mode == 0) ? 1'b1 : ((n % 4 == 0) || (n % 4 == 3));
         bus.start   = (n == mid);
         tick();
      end
      bus.start = 1'b0;
      to = (done_cnt == d0);
      bus.w_ready = 1'b0;
      repeat (3) tick();
   endtask

   task automatic run_fetch(input int mode, input int mid, output int start_cyc,
                            output bit to);
      int d0;
      clear_mon();
      d0 = done_cnt;
      bus.w_ready = 1'b1;
      bus.start = 1'b1;
      start_cyc = cyc;
      tick();
      bus.start = 1'b0;
      wait_done(mode, mid, d0, to);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0; bus.ld_valid = 1'b0; bus.ld_data = '0; bus.w_ready = 1'b0;
      repeat (3) tick();
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b want=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b want=0", bus.done); end
      checks++; if (bus.load_done !== 1'b0) begin failures++; $display("FAIL reset_load_done got=%0b want=0", bus.load_done); end
      checks++; if (bus.w_valid !== 1'b0) begin failures++; $display("FAIL reset_w_valid got=%0b want=0", bus.w_valid); end
      checks++; if (bus.w_last !== 1'b0) begin failures++; $display("FAIL reset_w_last got=%0b want=0", bus.w_last); end
      checks++; if (bus.w_data !== 16'h0) begin failures++; $display("FAIL reset_w_data got=%h want=0000", bus.w_data); end
      checks++; if (bus.bram_en !== 1'b0 || bus.bram_we !== 1'b0) begin failures++; $display("FAIL reset_bram_en_we got=%0b%0b want=00", bus.bram_en, bus.bram_we); end
      checks++; if (bus.bram_addr !== 5'd0 || bus.bram_di !== 16'h0) begin failures++; $display("FAIL reset_bram_addr_di got=%0d/%h want=0/0000", bus.bram_addr, bus.bram_di); end
      checks++; if (bus.ld_ready !== 1'b1) begin failures++; $display("FAIL reset_ld_ready got=%0b want=1", bus.ld_ready); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_load_fetch();
      int ld0, wr0, d0, sc;
      bit to;
      for (int i = 0; i < DEPTH; i++) exp_w[i] = 16'h0100 + 16'(i);
      ld0 = load_done_cnt; wr0 = wr_cnt;
      load_image(-1);
      checks++; if (load_done_cnt - ld0 !== 1) begin failures++; $display("FAIL load_done_pulses got=%0d want=1", load_done_cnt - ld0); end
      checks++; if (wr_cnt - wr0 !== DEPTH) begin failures++; $display("FAIL load_writes got=%0d want=%0d", wr_cnt - wr0, DEPTH); end
      checks++; if (image_errs() !== 0) begin failures++; $display("FAIL load_image got=%0d bad words want=0", image_errs()); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL load_busy_after got=%0b want=0", bus.busy); end
      d0 = done_cnt;
      run_fetch(0, -1, sc, to);
      checks++; if (to) begin failures++; $display("FAIL fetch_timeout got=no DONE want=DONE"); end
      checks++; if (stream_errs() !== 0) begin failures++; $display("FAIL fetch_stream got=%0d errors want=0", stream_errs()); end
      checks++; if (first_valid_cyc - sc !== 2) begin failures++; $display("FAIL fetch_first_valid got=%0d want=2 cycles", first_valid_cyc - sc); end
      checks++;
      if (beat_c.size() != DEPTH || beat_c[DEPTH-1] - beat_c[0] != DEPTH - 1) begin
         failures++; $display("FAIL fetch_consecutive got=%0d beats want=%0d back-to-back", beat_c.size(), DEPTH);
      end
      checks++; if (done_cnt - d0 !== 1 || done_bad !== 0) begin failures++; $display("FAIL fetch_done got=%0d pulses/%0d misplaced want=1/0", done_cnt - d0, done_bad); end
   endtask

   task automatic test_backpressure();
      int d0, sc;
      bit to;
      d0 = done_cnt;
      run_fetch(1, -1, sc, to);
      checks++; if (to) begin failures++; $display("FAIL bp_timeout got=no DONE want=DONE"); end
      checks++; if (stream_errs() !== 0) begin failures++; $display("FAIL bp_stream got=%0d errors want=0", stream_errs()); end
      checks++; if (hold_viol !== 0) begin failures++; $display("FAIL bp_hold got=%0d changes while stalled want=0", hold_viol); end
      checks++; if (en_viol !== 0) begin failures++; $display("FAIL bp_en_full got=%0d reads with 2 held want=0", en_viol); end
      checks++; if (done_cnt - d0 !== 1 || done_bad !== 0) begin failures++; $display("FAIL bp_done got=%0d pulses/%0d misplaced want=1/0", done_cnt - d0, done_bad); end
   endtask

   task automatic test_collision();
      int wr0, d0;
      bit to;
      clear_mon();
      wr0 = wr_cnt; d0 = done_cnt;
      bus.start = 1'b1; bus.ld_valid = 1'b1; bus.ld_data = 16'hDEAD; bus.w_ready = 1'b1;
      #1;
      checks++; if (bus.ld_ready !== 1'b0) begin failures++; $display("FAIL coll_ld_ready got=%0b want=0", bus.ld_ready); end
      tick();
      bus.start = 1'b0; bus.ld_valid = 1'b0;
      checks++; if (bus.busy !== 1'b1 || bus.bram_en !== 1'b1 || bus.bram_we !== 1'b0) begin
         failures++; $display("FAIL coll_fetch got=busy%0b en%0b we%0b want=busy1 en1 we0", bus.busy, bus.bram_en, bus.bram_we);
      end
      wait_done(0, -1, d0, to);
      checks++; if (to || stream_errs() !== 0) begin failures++; $display("FAIL coll_stream got=%0d errors timeout=%0b want=0/0", stream_errs(), to); end
      checks++; if (wr_cnt - wr0 !== 0) begin failures++; $display("FAIL coll_no_write got=%0d writes want=0", wr_cnt - wr0); end
   endtask

   task automatic test_ignored_start();
      int ld0, wr0, d0, sc;
      bit to;
      for (int i = 0; i < DEPTH; i++) exp_w[i] = 16'h0A00 + 16'(3 * i);
      ld0 = load_done_cnt; wr0 = wr_cnt;
      load_image(10);
      checks++; if (load_done_cnt - ld0 !== 1 || wr_cnt - wr0 !== DEPTH) begin
         failures++; $display("FAIL ign_load got=%0d load_done/%0d writes want=1/%0d", load_done_cnt - ld0, wr_cnt - wr0, DEPTH);
      end
      checks++; if (image_errs() !== 0 || bus.busy !== 1'b0) begin failures++; $display("FAIL ign_image got=%0d bad busy=%0b want=0/0", image_errs(), bus.busy); end
      d0 = done_cnt;
      run_fetch(0, 8, sc, to);
      repeat (5) tick();
      checks++; if (to || stream_errs() !== 0) begin failures++; $display("FAIL ign_stream got=%0d errors timeout=%0b want=0/0", stream_errs(), to); end
      checks++; if (done_cnt - d0 !== 1 || bus.busy !== 1'b0) begin failures++; $display("FAIL ign_done got=%0d pulses busy=%0b want=1/0", done_cnt - d0, bus.busy); end
   endtask

   task automatic test_reset_mid_fetch();
      int sc;
      bit to;
      clear_mon();
      bus.w_ready = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int n = 0; n < 50 && beat_d.size() < 5; n++) tick();
      checks++; if (beat_d.size() < 5) begin failures++; $display("FAIL rst_pre_beats got=%0d want=5", beat_d.size()); end
      rst = 1'b1; bus.w_ready = 1'b0;
      tick();
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.load_done !== 1'b0) begin
         failures++; $display("FAIL rst_status got=busy%0b done%0b ld%0b want=000", bus.busy, bus.done, bus.load_done);
      end
      checks++; if (bus.w_valid !== 1'b0 || bus.w_last !== 1'b0 || bus.w_data !== 16'h0) begin
         failures++; $display("FAIL rst_stream got=v%0b l%0b d%h want=v0 l0 d0000", bus.w_valid, bus.w_last, bus.w_data);
      end
      checks++; if (bus.bram_en !== 1'b0 || bus.bram_we !== 1'b0 || bus.bram_addr !== 5'd0 || bus.bram_di !== 16'h0) begin
         failures++; $display("FAIL rst_bram got=en%0b we%0b a%0d di%h want=0 0 0 0000", bus.bram_en, bus.bram_we, bus.bram_addr, bus.bram_di);
      end
      rst = 1'b0;
      tick();
      run_fetch(0, -1, sc, to);
      checks++; if (to || stream_errs() !== 0) begin failures++; $display("FAIL rst_restream got=%0d errors timeout=%0b want=0/0", stream_errs(), to); end
   endtask

   task automatic test_last_stall();
      int d0;
      bit found = 1'b0;
      clear_mon();
      d0 = done_cnt;
      bus.w_ready = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int n = 0; n < 100 && !found; n++) begin
         if (bus.w_valid && bus.w_last) found = 1'b1;
         else tick();
      end
      checks++; if (!found) begin failures++; $display("FAIL stall_reach_last got=not seen want=last at head"); end
      bus.w_ready = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (bus.busy !== 1'b1 || bus.w_valid !== 1'b1 || bus.w_last !== 1'b1 ||
             bus.w_data !== exp_w[DEPTH-1] || bus.done !== 1'b0) begin
            failures++; $display("FAIL stall_hold got=b%0b v%0b l%0b d%h dn%0b want=b1 v1 l1 d%h dn0", bus.busy, bus.w_valid, bus.w_last, bus.w_data, bus.done, exp_w[DEPTH-1]);
         end
      end
      bus.w_ready = 1'b1;
      #1;
      checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL stall_done got=%0b want=1", bus.done); end
      tick();
      bus.w_ready = 1'b0;
      checks++; if (bus.busy !== 1'b0 || bus.w_valid !== 1'b0) begin failures++; $display("FAIL stall_idle got=b%0b v%0b want=b0 v0", bus.busy, bus.w_valid); end
      repeat (2) tick();
      checks++; if (done_cnt - d0 !== 1 || stream_errs() !== 0) begin failures++; $display("FAIL stall_stream got=%0d pulses %0d errors want=1/0", done_cnt - d0, stream_errs()); end
   endtask

   initial begin
      test_reset();
      test_load_fetch();
      test_backpressure();
      test_collision();
      test_ignored_start();
      test_reset_mid_fetch();
      test_last_stall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
